// File: rtl/noc_requester_ni_pkg.sv
// Package pa_noc: shared definitions for the requester-side network interface.
// Holds the APB and packet widths, the bit positions of every packet field,
// and the state enumeration of the requester FSM.
//
// Packet layout (60 bits). An all-zero bus means "no packet":
//   [1:0]  destination column    [3:2]  destination row
//   [5:4]  source column         [7:6]  source row
//   [8]    valid                 [9]    write
//   [10]   response              [11]   error
//   [27:12] remote address       [59:28] data
package pa_noc;

    localparam int APB_ADDR_WIDTH    = 20;
    localparam int APB_DATA_WIDTH    = 32;
    localparam int APB_PACKET_WIDTH  = 60;
    localparam int REMOTE_ADDR_WIDTH = 16;

    localparam int DST_COL_LSB = 0;
    localparam int DST_ROW_LSB = 2;
    localparam int SRC_COL_LSB = 4;
    localparam int SRC_ROW_LSB = 6;
    localparam int VALID_BIT   = 8;
    localparam int WRITE_BIT   = 9;
    localparam int RESP_BIT    = 10;
    localparam int ERR_BIT     = 11;
    localparam int ADDR_LSB    = 12;
    localparam int DATA_LSB    = 28;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/noc_requester_ni.sv
// noc_requester_ni: requester-side network interface for one mesh node.
// Accepts APB transfers from the local host, sends each one as a single-cycle
// request packet into the local router, waits for the matching response
// packet and then completes the APB transfer. Incoming request packets belong
// to the target-side block and are ignored here.
//
// Ports:
//   i_clk, i_arst_n          clock, asynchronous active-low reset
//   i_psel, i_penable        APB select / enable
//   i_pwrite                 APB write (1) or read (0)
//   i_paddr[19:0]            [19:18] dest row, [17:16] dest col, [15:0] remote addr
//   i_pwdata[31:0]           APB write data
//   o_prdata[31:0]           APB read data, valid only while o_pready is high
//   o_pready                 one-cycle completion strobe
//   o_pslverr                completion error (local target, timeout, remote error)
//   o_packet                 request packet to router NI input (one cycle per request)
//   i_packet                 packet from router NI output
module noc_requester_ni
    import pa_noc::*;
#(
    parameter int NODE_ROW       = 0,
    parameter int NODE_COL       = 0,
    parameter int GRID_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        i_clk,
    input  logic                        i_arst_n,
    input  logic                        i_psel,
    input  logic                        i_penable,
    input  logic                        i_pwrite,
    input  logic [APB_ADDR_WIDTH-1:0]   i_paddr,
    input  logic [APB_DATA_WIDTH-1:0]   i_pwdata,
    output logic [APB_DATA_WIDTH-1:0]   o_prdata,
    output logic                        o_pready,
    output logic                        o_pslverr,
    output logic [APB_PACKET_WIDTH-1:0] o_packet,
    input  logic [APB_PACKET_WIDTH-1:0] i_packet
);

    localparam int COORD_W = $clog2(GRID_WIDTH);
    localparam int CNT_W   = $clog2(TIMEOUT_CYCLES);

    localparam logic [COORD_W-1:0] OWN_ROW  = COORD_W'(NODE_ROW);
    localparam logic [COORD_W-1:0] OWN_COL  = COORD_W'(NODE_COL);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                  state;
    logic [CNT_W-1:0]        count;
    logic [COORD_W-1:0]      dst_row;
    logic [COORD_W-1:0]      dst_col;
    logic                    is_write;

    logic [COORD_W-1:0]          req_row;
    logic [COORD_W-1:0]          req_col;
    logic                        req_local;
    logic [APB_PACKET_WIDTH-1:0] req_packet;
    logic                        rsp_match;
    logic [APB_DATA_WIDTH-1:0]   rsp_data;
    logic                        unused_packet_bits;

    assign req_row   = i_paddr[APB_ADDR_WIDTH-1 -: COORD_W];
    assign req_col   = i_paddr[APB_ADDR_WIDTH-1-COORD_W -: COORD_W];
    assign req_local = (req_row == OWN_ROW) && (req_col == OWN_COL);

    // Request packet built straight from the APB setup phase so it can be
    // registered onto o_packet on the capture edge.
    always_comb begin
        req_packet = '0;
        req_packet[DST_COL_LSB +: COORD_W]         = req_col;
        req_packet[DST_ROW_LSB +: COORD_W]         = req_row;
        req_packet[SRC_COL_LSB +: COORD_W]         = OWN_COL;
        req_packet[SRC_ROW_LSB +: COORD_W]         = OWN_ROW;
        req_packet[VALID_BIT]                      = 1'b1;
        req_packet[WRITE_BIT]                      = i_pwrite;
        req_packet[ADDR_LSB +: REMOTE_ADDR_WIDTH]  = i_paddr[REMOTE_ADDR_WIDTH-1:0];
        req_packet[DATA_LSB +: APB_DATA_WIDTH]     = i_pwrite ? i_pwdata : '0;
    end

    // A response is ours only if it is addressed to this node and comes back
    // from the node we sent the outstanding request to.
    assign rsp_match = i_packet[VALID_BIT] && i_packet[RESP_BIT]
                    && (i_packet[DST_ROW_LSB +: COORD_W] == OWN_ROW)
                    && (i_packet[DST_COL_LSB +: COORD_W] == OWN_COL)
                    && (i_packet[SRC_ROW_LSB +: COORD_W] == dst_row)
                    && (i_packet[SRC_COL_LSB +: COORD_W] == dst_col);
    assign rsp_data  = i_packet[DATA_LSB +: APB_DATA_WIDTH];

    // The echoed write flag and address of a response carry nothing we need.
    assign unused_packet_bits = ^{i_packet[WRITE_BIT], i_packet[ADDR_LSB +: REMOTE_ADDR_WIDTH]};

    // o_packet defaults to zero every cycle so a request is visible for
    // exactly one cycle. The response check comes before the expiry check so
    // a response arriving on the last wait cycle still completes cleanly.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state     <= IDLE;
            count     <= '0;
            dst_row   <= '0;
            dst_col   <= '0;
            is_write  <= 1'b0;
            o_prdata  <= '0;
            o_pready  <= 1'b0;
            o_pslverr <= 1'b0;
            o_packet  <= '0;
        end else begin
            o_packet <= '0;
            case (state)
                IDLE: begin
                    if (i_psel && !i_penable) begin
                        dst_row  <= req_row;
                        dst_col  <= req_col;
                        is_write <= i_pwrite;
                        count    <= '0;
                        if (req_local) begin
                            o_pready  <= 1'b1;
                            o_pslverr <= 1'b1;
                            o_prdata  <= '0;
                            state     <= DONE;
                        end else begin
                            o_packet <= req_packet;
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (rsp_match) begin
                        o_prdata  <= is_write ? '0 : rsp_data;
                        o_pslverr <= i_packet[ERR_BIT];
                        o_pready  <= 1'b1;
                        state     <= DONE;
                    end else if (count == CNT_LAST) begin
                        o_prdata  <= '0;
                        o_pslverr <= 1'b1;
                        o_pready  <= 1'b1;
                        state     <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    o_prdata  <= '0;
                    o_pready  <= 1'b0;
                    o_pslverr <= 1'b0;
                    count     <= '0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noc_requester_ni.sv
// tb_noc_requester_ni: bench for the requester network interface on node (1,1).
// Expected request packets and APB completions (data, error and the cycle
// they must appear in) are queued as stimulus is driven; a negedge monitor
// pops and compares them as the DUT produces packets and pready pulses.
module tb_noc_requester_ni;

    localparam int NROW = 1;
    localparam int NCOL = 1;
    localparam int TMO  = 16;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [19:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [59:0] pkt_out;
    logic [59:0] pkt_in = '0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] val;
        int          cyc;
    } exp_t;

    exp_t pkt_q[$];
    exp_t rsp_q[$];

    noc_requester_ni #(
        .NODE_ROW(NROW),
        .NODE_COL(NCOL),
        .GRID_WIDTH(4),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(clk),
        .i_arst_n(arst_n),
        .i_psel(psel),
        .i_penable(penable),
        .i_pwrite(pwrite),
        .i_paddr(paddr),
        .i_pwdata(pwdata),
        .o_prdata(prdata),
        .o_pready(pready),
        .o_pslverr(pslverr),
        .o_packet(pkt_out),
        .i_packet(pkt_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    function automatic logic [59:0] mkPacket(input logic [1:0] dr, input logic [1:0] dc,
                                              input logic [1:0] sr, input logic [1:0] sc,
                                              input logic v, input logic w, input logic r,
                                              input logic e, input logic [15:0] a,
                                              input logic [31:0] d);
        return {d, a, e, r, w, v, sr, sc, dr, dc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushRsp(input logic err, input logic [31:0] data, input int at);
        exp_t e;
        e.val = 64'({err, data});
        e.cyc = at;
        rsp_q.push_back(e);
    endtask

    // Drives the APB setup phase, queues what the DUT should produce for it,
    // then moves to the access phase.
    task automatic applyStimulus(input logic wr, input logic [19:0] addr, input logic [31:0] wdata);
        exp_t e;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        if (addr[19:18] == 2'(NROW) && addr[17:16] == 2'(NCOL)) begin
            pushRsp(1'b1, 32'h0, cyc + 1);
        end else begin
            e.val = 64'(mkPacket(addr[19:18], addr[17:16], 2'(NROW), 2'(NCOL), 1'b1, wr,
                                 1'b0, 1'b0, addr[15:0], wr ? wdata : 32'h0));
            e.cyc = cyc + 1;
            pkt_q.push_back(e);
        end
        tick();
        penable = 1'b1;
    endtask

    task automatic waitReady(input int bound);
        int n = 0;
        while (!pready && n < bound) begin
            tick();
            n++;
        end
        if (!pready) checkOutput("ready_wait", 64'(pready), 64'd1);
        tick();
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    task automatic sendPacket(input logic [59:0] p);
        pkt_in = p;
        tick();
        pkt_in = '0;
    endtask

    // Scoreboard monitor: every nonzero packet and every pready pulse must
    // match the head of its queue; outside pready the read data and error
    // must be zero.
    always @(negedge clk) begin
        exp_t e;
        if (arst_n) begin
            if (pkt_out != '0) begin
                if (pkt_q.size() == 0) begin
                    checkOutput("unexpected_pkt", 64'(pkt_out), 64'd0);
                end else begin
                    e = pkt_q.pop_front();
                    checkOutput("pkt", 64'(pkt_out), e.val);
                    checkOutput("pkt_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (pready) begin
                if (rsp_q.size() == 0) begin
                    checkOutput("unexpected_ready", 64'(pready), 64'd0);
                end else begin
                    e = rsp_q.pop_front();
                    checkOutput("rsp", 64'({pslverr, prdata}), e.val);
                    checkOutput("rsp_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else begin
                checkOutput("idle_rsp", 64'({pslverr, prdata}), 64'd0);
            end
        end
    end

    initial begin
        int s;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_pready", 64'(pready), 64'd0);
        checkOutput("reset_pslverr", 64'(pslverr), 64'd0);
        checkOutput("reset_prdata", 64'(prdata), 64'd0);
        checkOutput("reset_packet", 64'(pkt_out), 64'd0);
        arst_n = 1'b1;
        tick();

        $display("[TB] remote write to (2,3)");
        applyStimulus(1'b1, 20'hB0040, 32'hDEADBEEF);
        tick();
        pushRsp(1'b0, 32'h0, cyc + 1);
        sendPacket(mkPacket(2'd1, 2'd1, 2'd2, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0040, 32'h55555555));
        waitReady(8);
        tick();

        $display("[TB] remote read from (0,2)");
        applyStimulus(1'b0, 20'h20100, 32'hFFFFFFFF);
        tick();
        pushRsp(1'b0, 32'h12345678, cyc + 1);
        sendPacket(mkPacket(2'd1, 2'd1, 2'd0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0100, 32'h12345678));
        waitReady(8);
        tick();

        $display("[TB] read from (3,0) with no response");
        s = cyc;
        pushRsp(1'b1, 32'h0, s + 1 + TMO);
        applyStimulus(1'b0, 20'hC0200, 32'h0);
        waitReady(TMO + 4);
        sendPacket(mkPacket(2'd1, 2'd1, 2'd3, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0200, 32'h00000777));
        repeat (3) tick();

        $display("[TB] access to own coordinates");
        applyStimulus(1'b0, 20'h50010, 32'h0);
        waitReady(4);
        tick();

        $display("[TB] wrong source then correct response");
        applyStimulus(1'b0, 20'hB0080, 32'h0);
        sendPacket(mkPacket(2'd1, 2'd1, 2'd2, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0080, 32'h00000BAD));
        sendPacket(mkPacket(2'd1, 2'd1, 2'd2, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0080, 32'h00000BAD));
        sendPacket(mkPacket(2'd0, 2'd0, 2'd2, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0080, 32'h00000BAD));
        pushRsp(1'b1, 32'hCAFEF00D, cyc + 1);
        sendPacket(mkPacket(2'd1, 2'd1, 2'd2, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0080, 32'hCAFEF00D));
        waitReady(8);
        tick();

        $display("[TB] response on the last wait cycle");
        s = cyc;
        applyStimulus(1'b0, 20'h20300, 32'h0);
        while (cyc < s + TMO) tick();
        pushRsp(1'b0, 32'h0F0F0F0F, cyc + 1);
        sendPacket(mkPacket(2'd1, 2'd1, 2'd0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0300, 32'h0F0F0F0F));
        waitReady(4);
        tick();

        $display("[TB] reset during wait");
        applyStimulus(1'b0, 20'hB0080, 32'h0);
        tick();
        arst_n  = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        #1;
        checkOutput("midrst_pready", 64'(pready), 64'd0);
        checkOutput("midrst_pslverr", 64'(pslverr), 64'd0);
        checkOutput("midrst_prdata", 64'(prdata), 64'd0);
        checkOutput("midrst_packet", 64'(pkt_out), 64'd0);
        tick();
        arst_n = 1'b1;
        tick();
        sendPacket(mkPacket(2'd1, 2'd1, 2'd2, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0080, 32'h13579BDF));
        repeat (3) tick();

        applyStimulus(1'b1, 20'hF00AA, 32'h0BADCAFE);
        tick();
        pushRsp(1'b0, 32'h0, cyc + 1);
        sendPacket(mkPacket(2'd1, 2'd1, 2'd3, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 16'h00AA, 32'h0));
        waitReady(8);
        repeat (3) tick();

        checkOutput("pkt_q_empty", 64'(pkt_q.size()), 64'd0);
        checkOutput("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
